// File: rtl/sync_fifo_fwft.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo_fwft
//  Function : single-clock distributed-RAM FIFO with standard or FWFT read,
//             synchronous flush, sticky error flags and exact occupancy count.
//  Revision : 1.0
// ============================================================================
module sync_fifo_fwft #(
   parameter int ADDR_WIDTH       = 9,
   parameter int DATA_WIDTH       = 24,
   parameter int FWFT             = 1,
   parameter int ALMOST_FULL_NUM  = 4,
   parameter int ALMOST_EMPTY_NUM = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_en,
   output logic                  full,
   output logic                  almost_full,
   output logic                  overflow,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  empty,
   output logic                  almost_empty,
   output logic                  underflow,
   output logic [ADDR_WIDTH:0]   water_level
);

   localparam int                 c_DEPTH     = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] c_CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] c_PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0] c_FULL_LVL = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] c_AF_LVL   = c_FULL_LVL - (ADDR_WIDTH+1)'(ALMOST_FULL_NUM);
   localparam logic [ADDR_WIDTH:0] c_AE_LVL   = (ADDR_WIDTH+1)'(ALMOST_EMPTY_NUM);

   logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic                  r_overflow;
   logic                  r_underflow;

   logic w_full;
   logic w_empty;
   logic w_wr_accept;
   logic w_rd_accept;

   // Flags decode straight from the registered count.
   assign w_full       = (r_count == c_FULL_LVL);
   assign w_empty      = (r_count == '0);
   assign full         = w_full;
   assign empty        = w_empty;
   assign almost_full  = (r_count >= c_AF_LVL);
   assign almost_empty = (r_count <= c_AE_LVL);
   assign water_level  = r_count;
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

   // A flush blocks both ports for the cycle it is asserted.
   assign w_wr_accept = wr_en & ~w_full  & ~clr;
   assign w_rd_accept = rd_en & ~w_empty & ~clr;

   always_ff @(posedge clk) begin
      if (w_wr_accept) begin
         r_mem[r_wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else if (clr) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_wr_accept) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         end
         if (w_rd_accept) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         end
         case ({w_wr_accept, w_rd_accept})
            2'b10:   r_count <= r_count + c_CNT_ONE;
            2'b01:   r_count <= r_count - c_CNT_ONE;
            default: r_count <= r_count;
         endcase
         if (wr_en && w_full) begin
            r_overflow <= 1'b1;
         end
         if (rd_en && w_empty) begin
            r_underflow <= 1'b1;
         end
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         // Head word is always on the bus; rd_en acknowledges it.
         assign rd_data  = r_mem[r_rd_ptr];
         assign rd_valid = ~w_empty;
      end else begin : g_std
         logic [DATA_WIDTH-1:0] r_rd_data;
         logic                  r_rd_valid;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_rd_data  <= '0;
               r_rd_valid <= 1'b0;
            end else if (clr) begin
               r_rd_valid <= 1'b0;
            end else begin
               r_rd_valid <= w_rd_accept;
               if (w_rd_accept) begin
                  r_rd_data <= r_mem[r_rd_ptr];
               end
            end
         end

         assign rd_data  = r_rd_data;
         assign rd_valid = r_rd_valid;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_fwft.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sync_fifo_fwft
//  Function : bench for sync_fifo_fwft; a standard-mode and an FWFT instance
//             share stimulus and are checked against one queue model.
//  Revision : 1.0
// ============================================================================
module tb_sync_fifo_fwft;

   localparam int AW    = 4;
   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int AFN   = 4;
   localparam int AEN   = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          clr = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic          wr_en = 1'b0;
   logic          rd_en = 1'b0;

   logic          s_full, s_afull, s_ovf, s_rd_valid, s_empty, s_aempty, s_udf;
   logic [DW-1:0] s_rd_data;
   logic [AW:0]   s_level;
   logic          f_full, f_afull, f_ovf, f_rd_valid, f_empty, f_aempty, f_udf;
   logic [DW-1:0] f_rd_data;
   logic [AW:0]   f_level;

   int n_tests = 0;
   int n_fail  = 0;

   // Behavioural model
   logic [DW-1:0] q[$];
   logic          m_ovf = 1'b0;
   logic          m_udf = 1'b0;
   logic          m_valid = 1'b0;
   logic [DW-1:0] m_data = '0;

   always #5 clk = ~clk;

   sync_fifo_fwft #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(0),
                    .ALMOST_FULL_NUM(AFN), .ALMOST_EMPTY_NUM(AEN)) u_std (
      .clk(clk), .rst_n(rst_n), .clr(clr), .wr_data(wr_data), .wr_en(wr_en),
      .full(s_full), .almost_full(s_afull), .overflow(s_ovf), .rd_en(rd_en),
      .rd_data(s_rd_data), .rd_valid(s_rd_valid), .empty(s_empty),
      .almost_empty(s_aempty), .underflow(s_udf), .water_level(s_level));

   sync_fifo_fwft #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(1),
                    .ALMOST_FULL_NUM(AFN), .ALMOST_EMPTY_NUM(AEN)) u_fwft (
      .clk(clk), .rst_n(rst_n), .clr(clr), .wr_data(wr_data), .wr_en(wr_en),
      .full(f_full), .almost_full(f_afull), .overflow(f_ovf), .rd_en(rd_en),
      .rd_data(f_rd_data), .rd_valid(f_rd_valid), .empty(f_empty),
      .almost_empty(f_aempty), .underflow(f_udf), .water_level(f_level));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // FIFO semantics as a queue: accept decisions use the occupancy before the edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_ovf = 1'b0; m_udf = 1'b0; m_valid = 1'b0; m_data = '0;
      end else if (clr) begin
         q.delete();
         m_ovf = 1'b0; m_udf = 1'b0; m_valid = 1'b0;
      end else begin
         automatic int  n  = q.size();
         automatic bit  wa = wr_en && (n < DEPTH);
         automatic bit  ra = rd_en && (n > 0);
         if (wr_en && n == DEPTH) m_ovf = 1'b1;
         if (rd_en && n == 0)     m_udf = 1'b1;
         m_valid = ra;
         if (ra) m_data = q.pop_front();
         if (wa) q.push_back(wr_data);
      end
   end

   always @(negedge clk) begin
      automatic int n = q.size();
      chk("s_full",   s_full,   n == DEPTH);
      chk("f_full",   f_full,   n == DEPTH);
      chk("s_afull",  s_afull,  (DEPTH - n) <= AFN);
      chk("f_afull",  f_afull,  (DEPTH - n) <= AFN);
      chk("s_empty",  s_empty,  n == 0);
      chk("f_empty",  f_empty,  n == 0);
      chk("s_aempty", s_aempty, n <= AEN);
      chk("f_aempty", f_aempty, n <= AEN);
      chk("s_level",  s_level,  n);
      chk("f_level",  f_level,  n);
      chk("s_ovf",    s_ovf,    m_ovf);
      chk("f_ovf",    f_ovf,    m_ovf);
      chk("s_udf",    s_udf,    m_udf);
      chk("f_udf",    f_udf,    m_udf);
      chk("s_valid",  s_rd_valid, m_valid);
      chk("s_data",   s_rd_data,  m_data);
      chk("f_valid",  f_rd_valid, n != 0);
      if (n != 0) chk("f_data", f_rd_data, q[0]);
   end

   task automatic cyc(input logic we, input logic [DW-1:0] wd, input logic re, input logic cl);
      wr_en = we; wr_data = wd; rd_en = re; clr = cl;
      @(posedge clk); #2;
      wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_level", s_level, 0);
      chk("rst_empty", s_empty, 1);
      chk("rst_aempty", f_aempty, 1);
      chk("rst_full", s_full, 0);
      chk("rst_afull", s_afull, 0);
      chk("rst_sdata", s_rd_data, 0);
      chk("rst_svalid", s_rd_valid, 0);
      rst_n = 1'b1;

      // 1: fill, overflow, drain in order
      for (int i = 1; i <= DEPTH; i++) begin
         cyc(1'b1, DW'(i), 1'b0, 1'b0);
         if (i == 11) chk("t1_afull_11", s_afull, 0);
         if (i == 12) chk("t1_afull_12", s_afull, 1);
      end
      chk("t1_full", s_full, 1);
      chk("t1_level16", s_level, 16);
      cyc(1'b1, 8'h11, 1'b0, 1'b0);
      chk("t1_ovf", s_ovf, 1);
      chk("t1_level_hold", s_level, 16);
      for (int i = 1; i <= DEPTH; i++) begin
         cyc(1'b0, '0, 1'b1, 1'b0);
         chk("t1_rdata", s_rd_data, i);
         chk("t1_rvalid", s_rd_valid, 1);
      end
      chk("t1_empty", s_empty, 1);
      cyc(1'b0, '0, 1'b0, 1'b0);
      chk("t1_rvalid_drop", s_rd_valid, 0);
      cyc(1'b0, '0, 1'b0, 1'b1);

      // 2: FWFT fall-through
      cyc(1'b1, 8'hAA, 1'b0, 1'b0);
      chk("t2_fdata", f_rd_data, 8'hAA);
      chk("t2_fempty", f_empty, 0);
      chk("t2_fvalid", f_rd_valid, 1);
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("t2_fempty_after", f_empty, 1);
      chk("t2_level", f_level, 0);

      // 3: simultaneous at full
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, DW'(8'h20 + i), 1'b0, 1'b0);
      cyc(1'b1, 8'h99, 1'b1, 1'b0);
      chk("t3_sdata", s_rd_data, 8'h20);
      chk("t3_ovf", s_ovf, 1);
      chk("t3_level", s_level, 15);
      cyc(1'b0, '0, 1'b0, 1'b1);

      // 4: simultaneous at empty
      cyc(1'b1, 8'h55, 1'b1, 1'b0);
      chk("t4_udf", s_udf, 1);
      chk("t4_level", s_level, 1);
      chk("t4_fdata", f_rd_data, 8'h55);
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("t4_sdata", s_rd_data, 8'h55);
      cyc(1'b0, '0, 1'b0, 1'b1);

      // 5: wrap-around
      for (int i = 0; i < 10; i++) cyc(1'b1, DW'(8'h40 + i), 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) cyc(1'b0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 12; i++) cyc(1'b1, DW'(8'h60 + i), 1'b0, 1'b0);
      chk("t5_fhead", f_rd_data, 8'h60);
      for (int i = 0; i < 12; i++) begin
         cyc(1'b0, '0, 1'b1, 1'b0);
         chk("t5_sdata", s_rd_data, 8'h60 + i);
      end
      chk("t5_ovf", s_ovf, 0);
      chk("t5_udf", s_udf, 0);

      // 6a: flush with write in the same cycle
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, DW'(i), 1'b0, 1'b0);
      cyc(1'b1, 8'hEE, 1'b0, 1'b0);
      for (int i = 0; i < 9; i++) cyc(1'b0, '0, 1'b1, 1'b0);
      chk("t6_level7", s_level, 7);
      cyc(1'b1, 8'h77, 1'b0, 1'b1);
      chk("t6_level0", s_level, 0);
      chk("t6_empty", f_empty, 1);
      chk("t6_ovf_clr", s_ovf, 0);
      chk("t6_fvalid", f_rd_valid, 0);

      // 6b: asynchronous reset in the middle of a write burst
      for (int i = 0; i < 5; i++) cyc(1'b1, DW'(8'h80 + i), 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0);
      wr_en = 1'b1; wr_data = 8'h90;
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_level", s_level, 0);
      chk("t6_rst_empty", f_empty, 1);
      chk("t6_rst_sdata", s_rd_data, 0);
      chk("t6_rst_svalid", s_rd_valid, 0);
      chk("t6_rst_fvalid", f_rd_valid, 0);
      wr_en = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b1;
      cyc(1'b1, 8'hC3, 1'b0, 1'b0);
      chk("t6_first_f", f_rd_data, 8'hC3);
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("t6_first_s", s_rd_data, 8'hC3);

      // Randomised traffic with alternating fill/drain bias
      for (int i = 0; i < 4000; i++) begin
         automatic int wp = ((i / 300) % 2 == 0) ? 75 : 30;
         cyc(($urandom_range(0, 99) < wp) ? 1'b1 : 1'b0,
             DW'($urandom),
             ($urandom_range(0, 99) < 100 - wp) ? 1'b1 : 1'b0,
             ($urandom_range(0, 127) == 0) ? 1'b1 : 1'b0);
      end

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
